// File: rtl/ternary.sv
// rtl/ternary.sv - unsigned max selector with registered copy and saturating difference counter
// Optional eq_q output enabled by defining TERNARY_EQ_EN.
module ternary #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic [CNT_W-1:0] diff_cnt
`ifdef TERNARY_EQ_EN
    ,
    output logic             eq_q
`endif
);

    logic [WIDTH-1:0] c_d;
    logic [CNT_W-1:0] diff_cnt_d;
    logic [CNT_W-1:0] diff_cnt_q;

    // Ties resolve to b, which has the same value as a.
    assign c        = (a > b) ? a : b;
    assign diff_cnt = diff_cnt_q;

    always_comb begin
        c_d        = c;
        diff_cnt_d = diff_cnt_q;
        if ((a != b) && (diff_cnt_q != {CNT_W{1'b1}})) begin
            diff_cnt_d = diff_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q        <= '0;
            diff_cnt_q <= '0;
        end else begin
            c_q        <= c_d;
            diff_cnt_q <= diff_cnt_d;
        end
    end

`ifdef TERNARY_EQ_EN
    logic eq_d;

    always_comb begin
        eq_d = (a == b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
        end
    end
`endif

endmodule

// File: tb/tb_ternary.sv
// tb/tb_ternary.sv - randomized and directed self-checking bench for ternary
module tb_ternary;

    logic       clk;
    logic       rst;
    logic       a1, b1;
    logic [3:0] a4, b4;
    logic       c1, c1_q;
    logic [7:0] cnt1;
    logic [3:0] c4, c4_q;
    logic [1:0] cnt4;
`ifdef TERNARY_EQ_EN
    logic       eq1, eq4;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Reference state, integer-valued
    int m_cq1, m_cnt1, m_cq4, m_cnt4, m_eq1, m_eq4;

    ternary #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .c_q(c1_q), .diff_cnt(cnt1)
`ifdef TERNARY_EQ_EN
        , .eq_q(eq1)
`endif
    );

    ternary #(.WIDTH(4), .CNT_W(2)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .c_q(c4_q), .diff_cnt(cnt4)
`ifdef TERNARY_EQ_EN
        , .eq_q(eq4)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int larger(int x, int y);
        if (x >= y) return x;
        return y;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cq1 = 0; m_cnt1 = 0; m_cq4 = 0; m_cnt4 = 0; m_eq1 = 0; m_eq4 = 0;
        end else begin
            m_cq1 = larger(int'(a1), int'(b1));
            m_cq4 = larger(int'(a4), int'(b4));
            if (a1 != b1) m_cnt1 = (m_cnt1 + 1 > 255) ? 255 : m_cnt1 + 1;
            if (a4 != b4) m_cnt4 = (m_cnt4 + 1 > 3) ? 3 : m_cnt4 + 1;
            m_eq1 = (a1 == b1) ? 1 : 0;
            m_eq4 = (a4 == b4) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_c1", int'(c1), larger(int'(a1), int'(b1)));
            chk("m_c4", int'(c4), larger(int'(a4), int'(b4)));
            chk("m_c1_q", int'(c1_q), m_cq1);
            chk("m_c4_q", int'(c4_q), m_cq4);
            chk("m_cnt1", int'(cnt1), m_cnt1);
            chk("m_cnt4", int'(cnt4), m_cnt4);
`ifdef TERNARY_EQ_EN
            chk("m_eq1", int'(eq1), m_eq1);
            chk("m_eq4", int'(eq4), m_eq4);
`endif
        end
    end

    task automatic slot();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int sweep_c[4]   = '{0, 1, 1, 1};
        int sweep_cnt[4] = '{0, 1, 2, 2};
        int sat_cnt[5]   = '{1, 2, 3, 3, 3};
        a1 = 0; b1 = 0; a4 = 0; b4 = 0;
        rst = 0;
        #1 rst = 1;

        @(negedge clk);
        chk("rst_c1_q", int'(c1_q), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        chk("rst_cnt4", int'(cnt4), 0);
`ifdef TERNARY_EQ_EN
        chk("rst_eq1", int'(eq1), 0);
`endif
        #1 rst = 0;
        cmp_en = 1;

        // WIDTH=1 truth-table sweep, combinational then clocked
        for (int i = 0; i < 4; i++) begin
            slot();
            a1 = i[1]; b1 = i[0];
            #1 chk("sweep_c", int'(c1), sweep_c[i]);
            @(posedge clk); #1;
            chk("sweep_c_q", int'(c1_q), sweep_c[i]);
            chk("sweep_cnt", int'(cnt1), sweep_cnt[i]);
        end

        // Asynchronous reset between edges
        slot();
        chk("pre_rst_c_q", int'(c1_q), 1);
        rst = 1;
        #1;
        chk("async_c_q", int'(c1_q), 0);
        chk("async_cnt", int'(cnt1), 0);
        chk("c_during_rst", int'(c1), 1);
        #1 rst = 0;

        // CNT_W=2 saturation
        slot();
        a4 = 4'd1; b4 = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("sat_cnt4", int'(cnt4), sat_cnt[i]);
        end

        slot();
        a4 = 4'd9; b4 = 4'd9;
        #1 chk("w4_equal", int'(c4), 9);
        slot();
        a4 = 4'd3; b4 = 4'd12;
        #1 chk("w4_b_larger", int'(c4), 12);

`ifdef TERNARY_EQ_EN
        slot();
        a1 = 1; b1 = 1;
        @(posedge clk); #1;
        chk("eq_set", int'(eq1), 1);
        slot();
        a1 = 0; b1 = 1;
        @(posedge clk); #1;
        chk("eq_clr", int'(eq1), 0);
`endif

        // Randomized phase with occasional mid-cycle reset pulses
        for (int n = 0; n < 400; n++) begin
            slot();
            a1 = 1'($urandom); b1 = 1'($urandom);
            if ($urandom_range(0, 3) == 0) b4 = a4;
            else begin
                a4 = 4'($urandom); b4 = 4'($urandom);
            end
            if ($urandom_range(0, 49) == 0) begin
                #1 rst = 1;
                #1 rst = 0;
            end
        end

        slot();
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
